// File: rtl/fixed3_normalize_seq_if.sv
// Handshake bundle for the fixed-point 3-vector normaliser.
// Handshake rule (both directions): a transfer happens on a rising clock edge
// where valid and ready are both high; the sender holds valid and its payload
// steady until that edge, and the receiver may raise or drop ready freely.
interface fixed3_normalize_seq_if #(
    parameter int W  = 32,
    parameter int NF = 14
);
    localparam int OW = NF + 2;

    logic                 i_valid;
    logic                 i_ready;
    logic signed [W-1:0]  i_x;
    logic signed [W-1:0]  i_y;
    logic signed [W-1:0]  i_z;
    logic                 o_valid;
    logic                 o_ready;
    logic signed [OW-1:0] o_x;
    logic signed [OW-1:0] o_y;
    logic signed [OW-1:0] o_z;
    logic                 o_zero;

    // Normaliser side
    modport slave (
        input  i_valid, i_x, i_y, i_z, o_ready,
        output i_ready, o_valid, o_x, o_y, o_z, o_zero
    );

    // Upstream producer / downstream consumer side
    modport master (
        output i_valid, i_x, i_y, i_z, o_ready,
        input  i_ready, o_valid, o_x, o_y, o_z, o_zero
    );
endinterface

// File: rtl/fixed3_normalize_seq.sv
// Sequential 3-vector normaliser: sum of squares, bit-serial integer square
// root, then three serial restoring divisions producing signed Q1.NF results.
// The input fraction width does not appear in the datapath: the quotient
// |c|*2^NF/L is a ratio of two numbers with the same fraction position.
module fixed3_normalize_seq #(
    parameter int W  = 32,
    parameter int NF = 14
) (
    input  logic                   clk,
    input  logic                   resetn,
    fixed3_normalize_seq_if.slave  bus,
    output logic                   busy,
    output logic [2:0]             dbg_state
);
    localparam int SW = 2*W + 2;          // sum of squares
    localparam int LW = W + 1;            // square root
    localparam int RW = W + 4;            // sqrt partial remainder
    localparam int DW = W + 2;            // divider partial remainder
    localparam int QW = NF + 1;           // quotient magnitude
    localparam int OW = NF + 2;           // signed output
    localparam int CW = $clog2(LW + 1);   // step counter

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SQ   = 3'd1,
        S_SQRT = 3'd2,
        S_DIV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mx_q, mx_d, my_q, my_d, mz_q, mz_d;
    logic [2:0]      sgn_q, sgn_d;
    logic [SW-1:0]   s_q, s_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic [LW-1:0]   root_q, root_d;
    logic [DW-1:0]   dr_q, dr_d;
    logic [QW-1:0]   qt_q, qt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      comp_q, comp_d;
    logic [OW-1:0]   ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
    logic            zero_q, zero_d;

    // Two's complement magnitude; the most negative value maps to 2^(W-1)
    function automatic logic [W-1:0] mag_of(input logic [W-1:0] c);
        return c[W-1] ? (~c + 1'b1) : c;
    endfunction

    logic [2*W-1:0]  px, py, pz;
    logic [SW-1:0]   sum_sq;
    logic [RW-1:0]   rem_t, trial;
    logic            root_bit;
    logic            dr_ge;
    logic [DW-1:0]   dr_sub;
    logic [QW-1:0]   q_new;
    logic [OW-1:0]   res_mag, res;
    logic            cur_sgn;
    logic [W-1:0]    next_mag;

    assign px     = mx_q * mx_q;
    assign py     = my_q * my_q;
    assign pz     = mz_q * mz_q;
    assign sum_sq = {2'b00, px} + {2'b00, py} + {2'b00, pz};

    // One sqrt step: bring down the next two radicand bits and try root*4+1
    assign rem_t    = (rem_q << 2) | RW'(s_q[SW-1:SW-2]);
    assign trial    = RW'({root_q, 2'b01});
    assign root_bit = (rem_t >= trial);

    // One divide step: subtract the root when it fits; |c| <= L keeps q <= 2^NF
    assign dr_ge   = (dr_q >= DW'(root_q));
    assign dr_sub  = dr_ge ? (dr_q - DW'(root_q)) : dr_q;
    assign q_new   = (qt_q << 1) | QW'(dr_ge);
    assign res_mag = {1'b0, q_new};
    assign res     = cur_sgn ? (~res_mag + 1'b1) : res_mag;

    // Sign of the component being divided and magnitude of the one after it
    always_comb begin
        cur_sgn  = sgn_q[0];
        next_mag = my_q;
        case (comp_q)
            2'd0:    begin cur_sgn = sgn_q[0]; next_mag = my_q; end
            2'd1:    begin cur_sgn = sgn_q[1]; next_mag = mz_q; end
            default: begin cur_sgn = sgn_q[2]; next_mag = '0;   end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; a zero radicand leaves on the first sqrt cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.i_valid) state_d = S_SQ;
            S_SQ:   state_d = S_SQRT;
            S_SQRT: begin
                if (cnt_q == '0 && zero_q)          state_d = S_DONE;
                else if (cnt_q == CW'(LW - 1))      state_d = S_DIV;
            end
            S_DIV:  if (cnt_q == CW'(QW - 1) && comp_q == 2'd2) state_d = S_DONE;
            S_DONE: if (bus.o_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        bus.i_ready = (state_q == S_IDLE);
        bus.o_valid = (state_q == S_DONE);
        busy        = (state_q != S_IDLE);
        dbg_state   = state_q;
    end

    // Datapath next values
    always_comb begin
        mx_d   = mx_q;   my_d   = my_q;   mz_d   = mz_q;   sgn_d  = sgn_q;
        s_d    = s_q;    rem_d  = rem_q;  root_d = root_q;
        dr_d   = dr_q;   qt_d   = qt_q;   cnt_d  = cnt_q;  comp_d = comp_q;
        ox_d   = ox_q;   oy_d   = oy_q;   oz_d   = oz_q;   zero_d = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    mx_d   = mag_of(bus.i_x);
                    my_d   = mag_of(bus.i_y);
                    mz_d   = mag_of(bus.i_z);
                    sgn_d  = {bus.i_z[W-1], bus.i_y[W-1], bus.i_x[W-1]};
                    cnt_d  = '0;
                    comp_d = 2'd0;
                end
            end
            S_SQ: begin
                s_d    = sum_sq;
                zero_d = (sum_sq == '0);
                rem_d  = '0;
                root_d = '0;
                cnt_d  = '0;
            end
            S_SQRT: begin
                if (cnt_q == '0 && zero_q) begin
                    ox_d = '0;
                    oy_d = '0;
                    oz_d = '0;
                end else begin
                    rem_d  = root_bit ? (rem_t - trial) : rem_t;
                    root_d = (root_q << 1) | LW'(root_bit);
                    s_d    = s_q << 2;
                    if (cnt_q == CW'(LW - 1)) begin
                        cnt_d  = '0;
                        comp_d = 2'd0;
                        dr_d   = DW'(mx_q);
                        qt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DIV: begin
                qt_d = q_new;
                dr_d = dr_sub << 1;
                if (cnt_q == CW'(QW - 1)) begin
                    case (comp_q)
                        2'd0:    ox_d = res;
                        2'd1:    oy_d = res;
                        default: oz_d = res;
                    endcase
                    cnt_d  = '0;
                    comp_d = comp_q + 1'b1;
                    qt_d   = '0;
                    dr_d   = DW'(next_mag);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any vector in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mx_q <= '0; my_q <= '0; mz_q <= '0; sgn_q <= '0;
            s_q <= '0; rem_q <= '0; root_q <= '0;
            dr_q <= '0; qt_q <= '0; cnt_q <= '0; comp_q <= '0;
            ox_q <= '0; oy_q <= '0; oz_q <= '0; zero_q <= 1'b0;
        end else begin
            mx_q <= mx_d; my_q <= my_d; mz_q <= mz_d; sgn_q <= sgn_d;
            s_q <= s_d; rem_q <= rem_d; root_q <= root_d;
            dr_q <= dr_d; qt_q <= qt_d; cnt_q <= cnt_d; comp_q <= comp_d;
            ox_q <= ox_d; oy_q <= oy_d; oz_q <= oz_d; zero_q <= zero_d;
        end
    end

    assign bus.o_x    = ox_q;
    assign bus.o_y    = oy_q;
    assign bus.o_z    = oz_q;
    assign bus.o_zero = zero_q;
endmodule
